// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver and transmitter): line levels, parity sense, state encoding.
// The PARITY receive state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam logic UART_IDLE_LVL    = 1'b1;
    localparam logic PAR_ODD          = 1'b0;
    localparam int   MIN_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4,
        RX_BRK    = 3'd5
    } rx_st_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: counts 0..CLKS_PER_BIT-1 and wraps.
// Produces mid-bit and end-of-period strobes; restart holds the count at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic clr_n,
    input  logic restart,
    output logic mid,
    output logic fin
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] MID_V = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FIN_V = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clr_n || restart) begin
            cnt <= '0;
        end else if (cnt == FIN_V) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign mid = (cnt == MID_V);
    assign fin = (cnt == FIN_V);

endmodule

// File: rtl/uart_rx_hs.sv
// UART receiver with mid-bit sampling, false-start rejection, stop check and a four-phase req/ack
// holding register. Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_hs
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 rcv,
    input  logic                 rcv_ack,
    output logic                 rcv_req,
    output logic [DATA_BITS-1:0] rcv_data,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks
        $error("uart_rx_hs: CLKS_PER_BIT below minimum");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_hs: DATA_BITS outside 5..9");
    end

    rx_st_t st, st_nxt;

    logic                 rcv_meta, rs;
    logic                 tmr_restart, tmr_mid, tmr_fin;
    logic                 shift_en, commit_set, err_set, commit_pend, ack_wait;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_ok;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rcv_meta <= UART_IDLE_LVL;
            rs       <= UART_IDLE_LVL;
        end else begin
            rcv_meta <= rcv;
            rs       <= rcv_meta;
        end
    end

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .clr_n  (clr_n),
        .restart(tmr_restart),
        .mid    (tmr_mid),
        .fin    (tmr_fin)
    );

`ifdef UART_RX_PARITY_EN
    logic par_smp, par_bit;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            par_bit <= 1'b0;
        end else if (par_smp) begin
            par_bit <= rs;
        end
    end

    // Even parity: data ones plus the parity bit must sum to PAR_ODD.
    assign par_ok = (((^shreg) ^ par_bit) == PAR_ODD);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            st <= RX_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt      = st;
        tmr_restart = 1'b0;
        shift_en    = 1'b0;
        commit_set  = 1'b0;
        err_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp     = 1'b0;
`endif
        case (st)
            RX_IDLE: begin
                tmr_restart = 1'b1;
                if (rs != UART_IDLE_LVL) begin
                    st_nxt = RX_START;
                end
            end
            RX_START: begin
                // Re-centre the timer so later strobes land mid-bit.
                if (tmr_mid) begin
                    tmr_restart = 1'b1;
                    st_nxt      = (rs == UART_IDLE_LVL) ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tmr_fin) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        st_nxt = RX_PARITY;
`else
                        st_nxt = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tmr_fin) begin
                    par_smp = 1'b1;
                    st_nxt  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (tmr_fin) begin
                    if (rs != UART_IDLE_LVL) begin
                        err_set = 1'b1;
                        st_nxt  = RX_BRK;
                    end else if (par_ok) begin
                        commit_set = 1'b1;
                        st_nxt     = RX_IDLE;
                    end else begin
                        err_set = 1'b1;
                        st_nxt  = RX_IDLE;
                    end
                end
            end
            RX_BRK: begin
                tmr_restart = 1'b1;
                if (rs == UART_IDLE_LVL) begin
                    st_nxt = RX_IDLE;
                end
            end
            default: begin
                st_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (st != RX_DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg[bit_idx] <= rs;
            end
        end
    end

    // ack_wait covers the return-to-zero phase: no new word until ack drops.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
            rcv_req     <= 1'b0;
            rcv_data    <= '0;
            ack_wait    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            commit_pend <= commit_set;
            frame_err   <= err_set;
            if (rcv_req && rcv_ack) begin
                rcv_req  <= 1'b0;
                ack_wait <= 1'b1;
            end else if (ack_wait && !rcv_ack) begin
                ack_wait <= 1'b0;
            end
            if (commit_pend) begin
                if (!rcv_req && !ack_wait) begin
                    rcv_req  <= 1'b1;
                    rcv_data <= shreg;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_hs.sv
// Directed bench for uart_rx_hs: drives serial frames on rcv, answers the req/ack handshake,
// and compares each received word against the expected queue.
module tb_uart_rx_hs;
    import uart_pkg::*;

    localparam int DB = 8;
    localparam int C  = 8;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          rcv;
    logic          rcv_ack;
    logic          rcv_req;
    logic [DB-1:0] rcv_data;
    logic          frame_err;
    logic          overrun;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            err_pulses = 0;
    int            e0;
    logic          req_q = 1'b0;
    logic [DB-1:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic          par_flip = 1'b0;
`endif

    uart_rx_hs #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .rcv      (rcv),
        .rcv_ack  (rcv_ack),
        .rcv_req  (rcv_req),
        .rcv_data (rcv_data),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rcv = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ PAR_ODD ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    task automatic do_ack(input string tag);
        int t;
        t = 0;
        while (!rcv_req && t < 20 * C) begin
            tick(1);
            t++;
        end
        check({tag, "_req_seen"}, 32'(rcv_req), 32'd1);
        if (rcv_req) begin
            tick(3);
            rcv_ack = 1'b1;
            tick(1);
            check({tag, "_req_drop"}, 32'(rcv_req), 32'd0);
            rcv_ack = 1'b0;
            tick(2);
        end
    endtask

    // Scoreboard: every rising req must match the oldest expected word.
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (rcv_req && !req_q) begin
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_word", 32'(rcv_data), 32'(exp_q.pop_front()));
        end
        req_q = rcv_req;
    end

    initial begin
        clr_n   = 1'b0;
        rcv     = 1'b1;
        rcv_ack = 1'b0;
        tick(3);
        check("rst_req", 32'(rcv_req), 32'd0);
        check("rst_data", 32'(rcv_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        clr_n = 1'b1;
        tick(2 * C);

        // 1: clean frame and handshake
        e0 = err_pulses;
        exp_q.push_back(DB'(8'hA5));
        send_frame(DB'(8'hA5), 1'b1);
        do_ack("t1");
        check("t1_ferr", 32'(err_pulses - e0), 32'd0);
        check("t1_ovr", 32'(overrun), 32'd0);

        // 2: short low glitch is rejected
        e0 = err_pulses;
        rcv = 1'b0;
        tick(2);
        rcv = 1'b1;
        tick(2 * C);
        check("t2_req", 32'(rcv_req), 32'd0);
        check("t2_ferr", 32'(err_pulses - e0), 32'd0);
        check("t2_state", 32'(dut.st), 32'(RX_IDLE));

        // 3: bad stop bit, then recovery
        e0 = err_pulses;
        send_frame(DB'(8'h3C), 1'b0);
        rcv = 1'b1;
        tick(2 * C);
        check("t3_ferr_pulse", 32'(err_pulses - e0), 32'd1);
        check("t3_req", 32'(rcv_req), 32'd0);
        exp_q.push_back(DB'(8'h11));
        send_frame(DB'(8'h11), 1'b1);
        do_ack("t3b");

        // 4: back-to-back frames without ack
        exp_q.push_back(DB'(8'h01));
        send_frame(DB'(8'h01), 1'b1);
        send_frame(DB'(8'h02), 1'b1);
        tick(C);
        check("t4_req", 32'(rcv_req), 32'd1);
        check("t4_data_kept", 32'(rcv_data), 32'h01);
        check("t4_ovr", 32'(overrun), 32'd1);
        do_ack("t4");
        exp_q.push_back(DB'(8'h03));
        send_frame(DB'(8'h03), 1'b1);
        do_ack("t4b");
        check("t4_ovr_sticky", 32'(overrun), 32'd1);

        // 5: reset mid-DATA, then reset while req pending
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        clr_n = 1'b0;
        tick(1);
        check("t5_req", 32'(rcv_req), 32'd0);
        check("t5_data", 32'(rcv_data), 32'd0);
        check("t5_ferr", 32'(frame_err), 32'd0);
        check("t5_ovr", 32'(overrun), 32'd0);
        check("t5_state", 32'(dut.st), 32'(RX_IDLE));
        rcv = 1'b1;
        tick(2);
        clr_n = 1'b1;
        tick(2 * C);
        exp_q.push_back(DB'(8'h55));
        send_frame(DB'(8'h55), 1'b1);
        tick(2);
        check("t5_req_before", 32'(rcv_req), 32'd1);
        clr_n = 1'b0;
        tick(1);
        check("t5b_req", 32'(rcv_req), 32'd0);
        check("t5b_data", 32'(rcv_data), 32'd0);
        clr_n = 1'b1;
        tick(2 * C);
        e0 = err_pulses;
        exp_q.push_back(DB'(8'h7E));
        send_frame(DB'(8'h7E), 1'b1);
        do_ack("t5c");
        check("t5c_ferr", 32'(err_pulses - e0), 32'd0);
        check("t5c_ovr", 32'(overrun), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: parity error discards, correct parity accepted
        e0 = err_pulses;
        par_flip = 1'b1;
        send_frame(DB'(8'h07), 1'b1);
        tick(2 * C);
        check("t6_par_err", 32'(err_pulses - e0), 32'd1);
        check("t6_req", 32'(rcv_req), 32'd0);
        par_flip = 1'b0;
        exp_q.push_back(DB'(8'h07));
        send_frame(DB'(8'h07), 1'b1);
        do_ack("t6b");
`endif

        tick(C);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
